// File: rtl/ras_ctrl_pkg.sv
// Shared definitions for the return-address-stack controller: address width and FSM states.
package ras_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic {
    RAS_RUN     = 1'b0,
    RAS_RESTORE = 1'b1
  } ras_state_e;

endpackage

// File: rtl/ras_mem.sv
// RAS storage: register array with one synchronous write port and one asynchronous read port.
module ras_mem
  import ras_ctrl_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned PTR_W     = $clog2(ENTRY_NUM)
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  wen,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [ADDR_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] mem_q [ENTRY_NUM];

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) mem_q[i] <= '0;
    end else if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack controller: push/pop sequencing, single-level checkpoint and restore FSM.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned PTR_W     = $clog2(ENTRY_NUM)
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  dec_valid,
  input  logic                  call_dec,
  input  logic                  ret_dec,
  input  logic [ADDR_WIDTH-1:0] pc_dec,
  input  logic                  chk_save,
  input  logic                  chk_release,
  input  logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] ret_addr,
  output logic                  ret_valid,
  output logic                  stack_empty,
  output logic                  stack_full
);

  localparam int unsigned CNT_W = PTR_W + 1;

  ras_state_e            state_q, state_d;
  logic [PTR_W-1:0]      sp_q, sp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  chk_valid_q, chk_valid_d;
  logic [PTR_W-1:0]      chk_sp_q, chk_sp_d;
  logic [CNT_W-1:0]      chk_cnt_q, chk_cnt_d;
  logic [ADDR_WIDTH-1:0] chk_top_q, chk_top_d;
  logic                  rst_wr_q, rst_wr_d;

  logic                  mem_wen;
  logic [PTR_W-1:0]      mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] top_data;
  logic [PTR_W-1:0]      top;
  logic [ADDR_WIDTH-1:0] push_data;
  logic                  push, pop, save;
  logic                  is_empty, is_full;

  assign top       = sp_q - PTR_W'(1);
  assign push_data = pc_dec + ADDR_WIDTH'(4);
  assign is_empty  = (cnt_q == '0);
  assign is_full   = (cnt_q == CNT_W'(ENTRY_NUM));
  assign push      = dec_valid & call_dec;
  assign pop       = dec_valid & ret_dec;
  assign save      = dec_valid & chk_save;

  // Next-state, stack pointer/count, checkpoint and write-port mux.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    chk_valid_d = chk_valid_q;
    chk_sp_d    = chk_sp_q;
    chk_cnt_d   = chk_cnt_q;
    chk_top_d   = chk_top_q;
    rst_wr_d    = 1'b0;
    mem_wen     = 1'b0;
    mem_waddr   = sp_q;
    mem_wdata   = push_data;

    if (state_q == RAS_RESTORE) begin
      state_d = RAS_RUN;
      if (rst_wr_q) begin
        mem_wen   = 1'b1;
        mem_waddr = chk_sp_q - PTR_W'(1);
        mem_wdata = chk_top_q;
      end
    end else if (mispredict) begin
      state_d     = RAS_RESTORE;
      chk_valid_d = 1'b0;
      if (chk_valid_q) begin
        sp_d     = chk_sp_q;
        cnt_d    = chk_cnt_q;
        rst_wr_d = 1'b1;
      end else begin
        sp_d  = '0;
        cnt_d = '0;
      end
    end else begin
      if (push && pop) begin
        // Co-routine jump: replace top in place, or behave as a push when empty.
        mem_wen = 1'b1;
        if (is_empty) begin
          sp_d  = sp_q + PTR_W'(1);
          cnt_d = CNT_W'(1);
        end else begin
          mem_waddr = top;
        end
      end else if (push) begin
        mem_wen = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
        if (!is_full) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !is_empty) begin
        sp_d  = top;
        cnt_d = cnt_q - CNT_W'(1);
      end

      if (chk_release) chk_valid_d = 1'b0;
      if (save) begin
        chk_valid_d = 1'b1;
        chk_sp_d    = sp_q;
        chk_cnt_d   = cnt_q;
        chk_top_d   = top_data;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= RAS_RUN;
      sp_q        <= '0;
      cnt_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_sp_q    <= '0;
      chk_cnt_q   <= '0;
      chk_top_q   <= '0;
      rst_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      chk_valid_q <= chk_valid_d;
      chk_sp_q    <= chk_sp_d;
      chk_cnt_q   <= chk_cnt_d;
      chk_top_q   <= chk_top_d;
      rst_wr_q    <= rst_wr_d;
    end
  end

  ras_mem #(
    .ENTRY_NUM (ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) u_mem (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .wen      (mem_wen),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
    .raddr    (top),
    .rdata    (top_data)
  );

  assign ret_addr    = top_data;
  assign ret_valid   = (state_q == RAS_RUN) && !is_empty;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl with hand-computed expected stack contents.
module tb_ras_ctrl;
  import ras_ctrl_pkg::*;

  logic                  cpu_clk;
  logic                  cpu_rstn;
  logic                  dec_valid;
  logic                  call_dec;
  logic                  ret_dec;
  logic [ADDR_WIDTH-1:0] pc_dec;
  logic                  chk_save;
  logic                  chk_release;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  ret_valid;
  logic                  stack_empty;
  logic                  stack_full;

  int tests_run = 0;
  int tests_failed = 0;

  ras_ctrl #(.ENTRY_NUM(8)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .dec_valid   (dec_valid),
    .call_dec    (call_dec),
    .ret_dec     (ret_dec),
    .pc_dec      (pc_dec),
    .chk_save    (chk_save),
    .chk_release (chk_release),
    .mispredict  (mispredict),
    .ret_addr    (ret_addr),
    .ret_valid   (ret_valid),
    .stack_empty (stack_empty),
    .stack_full  (stack_full)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic v, input logic e, input logic f);
    check({tag, ".ret_valid"}, 32'(ret_valid), 32'(v));
    check({tag, ".stack_empty"}, 32'(stack_empty), 32'(e));
    check({tag, ".stack_full"}, 32'(stack_full), 32'(f));
  endtask

  // One clock with the given decode/branch controls; outputs settle 1 time unit after the edge.
  task automatic step(input logic c, input logic r, input logic [31:0] pc,
                      input logic s, input logic rel, input logic mis);
    dec_valid   = c | r | s;
    call_dec    = c;
    ret_dec     = r;
    pc_dec      = pc;
    chk_save    = s;
    chk_release = rel;
    mispredict  = mis;
    @(posedge cpu_clk);
    #1;
    dec_valid   = 1'b0;
    call_dec    = 1'b0;
    ret_dec     = 1'b0;
    pc_dec      = '0;
    chk_save    = 1'b0;
    chk_release = 1'b0;
    mispredict  = 1'b0;
  endtask

  task automatic call(input logic [31:0] pc);
    step(1'b1, 1'b0, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ret();
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cpu_rstn    = 1'b0;
    dec_valid   = 1'b0;
    call_dec    = 1'b0;
    ret_dec     = 1'b0;
    pc_dec      = '0;
    chk_save    = 1'b0;
    chk_release = 1'b0;
    mispredict  = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      idle();
      check_flags("reset_idle", 1'b0, 1'b1, 1'b0);
      check("reset_idle.ret_addr", ret_addr, 32'h0);
    end

    // Three calls then three returns in LIFO order
    call(32'h100);
    call(32'h200);
    call(32'h300);
    check_flags("lifo_pushed", 1'b1, 1'b0, 1'b0);
    check("lifo.top0", ret_addr, 32'h304);
    ret();
    check("lifo.top1", ret_addr, 32'h204);
    ret();
    check("lifo.top2", ret_addr, 32'h104);
    ret();
    check_flags("lifo_drained", 1'b0, 1'b1, 1'b0);

    // Overflow: 9 pushes overwrite the oldest entry; sp starts at 0
    for (int i = 0; i < 9; i++) call(32'h1000 + 32'(i) * 32'h10);
    check_flags("ovf_full", 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("ovf.pop_addr", ret_addr, 32'h1084 - 32'(k) * 32'h10);
      ret();
    end
    check_flags("ovf_drained", 1'b0, 1'b1, 1'b0);
    check("ovf.top_after_drain", ret_addr, 32'h1084);
    ret();
    check_flags("underflow", 1'b0, 1'b1, 1'b0);
    check("underflow.ret_addr", ret_addr, 32'h1084);

    // Checkpoint then mispredict restores the saved top (sp=1 here)
    call(32'h400);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    ret();
    call(32'h800);
    check("chk.before_mis", ret_addr, 32'h804);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("chk.restore_valid", 32'(ret_valid), 32'h0);
    idle();
    check_flags("chk_restored", 1'b1, 1'b0, 1'b0);
    check("chk.restored_addr", ret_addr, 32'h404);
    ret();
    check("chk.count_one", 32'(stack_empty), 32'h1);

    // Call+ret same cycle with count=2, then with count=0 (sp=1 here)
    call(32'hA00);
    call(32'hB00);
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    check("cr2.top", ret_addr, 32'h504);
    check_flags("cr2", 1'b1, 1'b0, 1'b0);
    ret();
    check("cr2.next", ret_addr, 32'hA04);
    check("cr2.not_empty", 32'(stack_empty), 32'h0);
    ret();
    check("cr2.empty", 32'(stack_empty), 32'h1);
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    check("cr0.top", ret_addr, 32'h504);
    check_flags("cr0", 1'b1, 1'b0, 1'b0);
    ret();
    check("cr0.empty", 32'(stack_empty), 32'h1);

    // Mispredict without checkpoint clears the stack (sp=1 here; mem[7] still 0x1074)
    call(32'h10);
    call(32'h20);
    call(32'h30);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("nochk.restore_valid", 32'(ret_valid), 32'h0);
    idle();
    check_flags("nochk_cleared", 1'b0, 1'b1, 1'b0);
    check("nochk.ret_addr", ret_addr, 32'h1074);

    // Released checkpoint is not restored
    call(32'h700);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    call(32'h900);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();
    check_flags("released", 1'b0, 1'b1, 1'b0);

    // Reset pulsed during RESTORE
    call(32'hC00);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    call(32'hD00);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cpu_rstn = 1'b0;
    #1;
    check_flags("rst_in_restore", 1'b0, 1'b1, 1'b0);
    check("rst_in_restore.ret_addr", ret_addr, 32'h0);
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    idle();
    check_flags("rst_released", 1'b0, 1'b1, 1'b0);
    check("rst_released.ret_addr", ret_addr, 32'h0);
    call(32'hE00);
    check("post_rst.push", ret_addr, 32'hE04);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
